// File: rtl/game_timer_ctrl.sv
// Game-round timer: counts prescaled steps from start to MAX_STEPS-1 and pulses end_trigger,
// with UART byte commands for bonus, penalty and pause, and an up/down display mapping.
module game_timer_ctrl #(
    parameter int         W             = 10,
    parameter int         CLK_TICKS     = 10_000_000,
    parameter int         MAX_STEPS     = 200,
    parameter int         BONUS_STEPS   = 20,
    parameter int         PENALTY_STEPS = 10,
    parameter int         WARN_STEPS    = 20,
    parameter logic [7:0] BONUS_CODE    = 8'h42,
    parameter logic [7:0] PENALTY_CODE  = 8'h58,
    parameter logic [7:0] PAUSE_CODE    = 8'h50,
    parameter bit         COUNT_DOWN    = 1'b0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [7:0]   data,
    input  logic         start_trigger,
    input  logic         abort,
    output logic [W-1:0] pixel_timer,
    output logic         end_trigger,
    output logic         running,
    output logic         paused,
    output logic         warn
);

    localparam int PW = (CLK_TICKS > 1) ? $clog2(CLK_TICKS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_TICKS - 1);
    localparam logic [W:0]    LAST     = (W+1)'(MAX_STEPS - 1);
    // Step constants are clamped to the round length so W+1 bits always suffice.
    localparam logic [W:0]    BONUS_W  = (W+1)'((BONUS_STEPS   > MAX_STEPS) ? MAX_STEPS : BONUS_STEPS);
    localparam logic [W:0]    PEN_W    = (W+1)'((PENALTY_STEPS > MAX_STEPS) ? MAX_STEPS : PENALTY_STEPS);
    localparam logic [W:0]    WARN_W   = (W+1)'((WARN_STEPS    > MAX_STEPS) ? MAX_STEPS : WARN_STEPS);
    localparam logic [W-1:0]  PIX_RST  = COUNT_DOWN ? W'(MAX_STEPS - 1) : '0;
    localparam logic [23:0]   CODES    = {PAUSE_CODE, PENALTY_CODE, BONUS_CODE};

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        state_reg, state_next;
    logic [W:0]    elapsed_reg, elapsed_next;
    logic [PW-1:0] prescaler_reg, prescaler_next;
    logic [7:0]    data_q, data_d;
    logic [2:0]    code_ev;
    logic          end_next, running_next, paused_next, warn_next, tick;
    logic [W-1:0]  pixel_next;

    // One event per byte arrival: the code must be new in data_q relative to data_d.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_code
            assign code_ev[gi] = (data_q == CODES[gi*8 +: 8]) && (data_d != CODES[gi*8 +: 8]);
        end
    endgenerate

    assign tick = (prescaler_reg == PRE_LAST);

    always_comb begin
        state_next     = state_reg;
        elapsed_next   = elapsed_reg;
        prescaler_next = prescaler_reg;
        end_next       = 1'b0;
        if (abort) begin
            state_next     = IDLE;
            elapsed_next   = '0;
            prescaler_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    elapsed_next   = '0;
                    prescaler_next = '0;
                    if (start_trigger) state_next = RUN;
                end
                RUN: begin
                    // The prescaler keeps its cadence even when a code event eats the step.
                    prescaler_next = tick ? '0 : prescaler_reg + 1'b1;
                    if (code_ev[2]) begin
                        state_next = PAUSE;
                    end else if (code_ev[0]) begin
                        elapsed_next = (elapsed_reg >= BONUS_W) ? elapsed_reg - BONUS_W : '0;
                    end else if (code_ev[1]) begin
                        elapsed_next = (elapsed_reg + PEN_W > LAST) ? LAST : elapsed_reg + PEN_W;
                    end else if (tick) begin
                        if (elapsed_reg >= LAST) begin
                            state_next = DONE;
                            end_next   = 1'b1;
                        end else begin
                            elapsed_next = elapsed_reg + 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (code_ev[2]) state_next = RUN;
                end
                DONE: begin
                    if (start_trigger) begin
                        state_next     = RUN;
                        elapsed_next   = '0;
                        prescaler_next = '0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        running_next = (state_next == RUN) || (state_next == PAUSE);
        paused_next  = (state_next == PAUSE);
        warn_next    = running_next && ((LAST - elapsed_next) <= WARN_W);
        pixel_next   = COUNT_DOWN ? W'(LAST - elapsed_next) : W'(elapsed_next);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            elapsed_reg   <= '0;
            prescaler_reg <= '0;
            data_q        <= '0;
            data_d        <= '0;
            pixel_timer   <= PIX_RST;
            end_trigger   <= 1'b0;
            running       <= 1'b0;
            paused        <= 1'b0;
            warn          <= 1'b0;
        end else begin
            state_reg     <= state_next;
            elapsed_reg   <= elapsed_next;
            prescaler_reg <= prescaler_next;
            data_q        <= data;
            data_d        <= data_q;
            pixel_timer   <= pixel_next;
            end_trigger   <= end_next;
            running       <= running_next;
            paused        <= paused_next;
            warn          <= warn_next;
        end
    end

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Scoreboard bench for game_timer_ctrl: an up-counting and a down-counting instance share stimulus;
// every output change is popped against a queued expected (cycle, outputs) record.
module tb_game_timer_ctrl;

    localparam logic [7:0] B_CODE = 8'h42;
    localparam logic [7:0] X_CODE = 8'h58;
    localparam logic [7:0] P_CODE = 8'h50;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] data = 8'h00;
    logic       start_trigger = 1'b0;
    logic       abort = 1'b0;

    logic [9:0] pix0, pix1;
    logic       end0, end1, run0, run1, pau0, pau1, warn0, warn1;

    int cyc = 0;
    int n_total = 0;
    int n_bad = 0;
    logic fin_req = 1'b0;

    typedef struct {
        int          cyc;
        logic [13:0] vec;   // {pixel, end, running, paused, warn}
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    game_timer_ctrl #(.W(10), .CLK_TICKS(4), .MAX_STEPS(10), .BONUS_STEPS(3), .PENALTY_STEPS(2),
                      .WARN_STEPS(2), .BONUS_CODE(B_CODE), .PENALTY_CODE(X_CODE),
                      .PAUSE_CODE(P_CODE), .COUNT_DOWN(1'b0)) dut_up (
        .clk(clk), .reset_n(reset_n), .data(data), .start_trigger(start_trigger), .abort(abort),
        .pixel_timer(pix0), .end_trigger(end0), .running(run0), .paused(pau0), .warn(warn0));

    game_timer_ctrl #(.W(10), .CLK_TICKS(4), .MAX_STEPS(10), .BONUS_STEPS(3), .PENALTY_STEPS(2),
                      .WARN_STEPS(2), .BONUS_CODE(B_CODE), .PENALTY_CODE(X_CODE),
                      .PAUSE_CODE(P_CODE), .COUNT_DOWN(1'b1)) dut_dn (
        .clk(clk), .reset_n(reset_n), .data(data), .start_trigger(start_trigger), .abort(abort),
        .pixel_timer(pix1), .end_trigger(end1), .running(run1), .paused(pau1), .warn(warn1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs for a given elapsed count; warn means at most 2 steps remain (elapsed >= 7).
    task automatic push(input int c, input int el, input logic e, input logic r, input logic p);
        exp_t        x;
        logic        w;
        int          dn;
        logic [9:0]  pu, pd;
        w  = r && (el >= 7);
        dn = 9 - el;
        pu = el[9:0];
        pd = dn[9:0];
        x.cyc = c;
        x.vec = {pu, e, r, p, w};
        q0.push_back(x);
        x.vec = {pd, e, r, p, w};
        q1.push_back(x);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // RUN becomes visible at cycle t with elapsed 0.
    task automatic start_round(output int t);
        @(negedge clk);
        t = cyc + 1;
        push(t, 0, 1'b0, 1'b1, 1'b0);
        start_trigger = 1'b1;
        @(negedge clk);
        start_trigger = 1'b0;
    endtask

    task automatic report(input int d, input logic [13:0] got, input exp_t e, input int now);
        $display("FAIL out_seq dut%0d: got pix=%0d end=%0b run=%0b pau=%0b warn=%0b @cyc %0d, required pix=%0d end=%0b run=%0b pau=%0b warn=%0b @cyc %0d",
                 d, got[13:4], got[3], got[2], got[1], got[0], now,
                 e.vec[13:4], e.vec[3], e.vec[2], e.vec[1], e.vec[0], e.cyc);
    endtask

    // Monitor: owns every comparison and the summary.
    initial begin
        logic [13:0] prev[2];
        logic [13:0] cur;
        exp_t        e;
        prev[0] = 14'h3fff;
        prev[1] = 14'h3fff;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                cur = (d == 0) ? {pix0, end0, run0, pau0, warn0} : {pix1, end1, run1, pau1, warn1};
                if (cur !== prev[d]) begin
                    prev[d] = cur;
                    n_total++;
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        n_bad++;
                        $display("FAIL unexpected_change dut%0d @cyc %0d: got pix=%0d end=%0b run=%0b pau=%0b warn=%0b, required no change",
                                 d, cyc, cur[13:4], cur[3], cur[2], cur[1], cur[0]);
                    end else begin
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        if (e.cyc != cyc || e.vec !== cur) begin
                            n_bad++;
                            report(d, cur, e, cyc);
                        end
                    end
                end
            end
            if (fin_req) begin
                n_total++;
                if (q0.size() != 0 || q1.size() != 0) begin
                    n_bad++;
                    $display("FAIL leftover_expected: got up=%0d dn=%0d pending, required 0",
                             q0.size(), q1.size());
                end
                $display("test done: total=%0d bad=%0d", n_total, n_bad);
                $finish;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        int t;
        // Reset state visible at the first sample.
        push(1, 0, 1'b0, 1'b0, 1'b0);
        wait_cyc(3);
        reset_n = 1'b1;

        // Full round: one step every 4 clk, end pulse on the tick after reaching 9.
        start_round(t);
        for (int k = 1; k <= 9; k++) push(t + 4*k, k, 1'b0, 1'b1, 1'b0);
        push(t + 40, 9, 1'b1, 1'b0, 1'b0);
        push(t + 41, 9, 1'b0, 1'b0, 1'b0);
        wait_cyc(t + 45);

        // Bonus: 2 -> 0 (clamped), 5 -> 2, held byte decrements once; restart from DONE.
        start_round(t);
        push(t + 4, 1, 1'b0, 1'b1, 1'b0);
        push(t + 8, 2, 1'b0, 1'b1, 1'b0);
        push(t + 10, 0, 1'b0, 1'b1, 1'b0);
        push(t + 12, 1, 1'b0, 1'b1, 1'b0);
        push(t + 16, 2, 1'b0, 1'b1, 1'b0);
        push(t + 20, 3, 1'b0, 1'b1, 1'b0);
        push(t + 24, 4, 1'b0, 1'b1, 1'b0);
        push(t + 28, 5, 1'b0, 1'b1, 1'b0);
        push(t + 30, 2, 1'b0, 1'b1, 1'b0);
        for (int j = 0; j < 7; j++) push(t + 32 + 4*j, 3 + j, 1'b0, 1'b1, 1'b0);
        push(t + 60, 9, 1'b1, 1'b0, 1'b0);
        push(t + 61, 9, 1'b0, 1'b0, 1'b0);
        wait_cyc(t + 8);  data = B_CODE;
        wait_cyc(t + 12); data = 8'h00;
        wait_cyc(t + 28); data = B_CODE;
        wait_cyc(t + 58); data = 8'h00;
        wait_cyc(t + 64);

        // Pause at elapsed 2 with prescaler 3, bonus ignored while paused, resume ticks at once.
        start_round(t);
        push(t + 4, 1, 1'b0, 1'b1, 1'b0);
        push(t + 8, 2, 1'b0, 1'b1, 1'b0);
        push(t + 11, 2, 1'b0, 1'b1, 1'b1);
        push(t + 33, 2, 1'b0, 1'b1, 1'b0);
        for (int j = 0; j < 7; j++) push(t + 34 + 4*j, 3 + j, 1'b0, 1'b1, 1'b0);
        push(t + 62, 9, 1'b1, 1'b0, 1'b0);
        push(t + 63, 9, 1'b0, 1'b0, 1'b0);
        wait_cyc(t + 9);  data = P_CODE;
        wait_cyc(t + 13); data = 8'h00;
        wait_cyc(t + 15); data = B_CODE;
        wait_cyc(t + 19); data = 8'h00;
        wait_cyc(t + 31); data = P_CODE;
        wait_cyc(t + 35); data = 8'h00;
        wait_cyc(t + 66);

        // Penalty: 3 -> 5, then 8 -> 9 clamped with no pulse until the next tick.
        start_round(t);
        push(t + 4, 1, 1'b0, 1'b1, 1'b0);
        push(t + 8, 2, 1'b0, 1'b1, 1'b0);
        push(t + 12, 3, 1'b0, 1'b1, 1'b0);
        push(t + 14, 5, 1'b0, 1'b1, 1'b0);
        push(t + 16, 6, 1'b0, 1'b1, 1'b0);
        push(t + 20, 7, 1'b0, 1'b1, 1'b0);
        push(t + 24, 8, 1'b0, 1'b1, 1'b0);
        push(t + 26, 9, 1'b0, 1'b1, 1'b0);
        push(t + 28, 9, 1'b1, 1'b0, 1'b0);
        push(t + 29, 9, 1'b0, 1'b0, 1'b0);
        wait_cyc(t + 12); data = X_CODE;
        wait_cyc(t + 16); data = 8'h00;
        wait_cyc(t + 24); data = X_CODE;
        wait_cyc(t + 28); data = 8'h00;
        wait_cyc(t + 32);

        // Abort at elapsed 6: back to IDLE, no end pulse.
        start_round(t);
        for (int k = 1; k <= 6; k++) push(t + 4*k, k, 1'b0, 1'b1, 1'b0);
        push(t + 26, 0, 1'b0, 1'b0, 1'b0);
        wait_cyc(t + 25); abort = 1'b1;
        wait_cyc(t + 26); abort = 1'b0;
        wait_cyc(t + 36);

        // Asynchronous reset mid-round: reset values appear before the next clock edge.
        start_round(t);
        push(t + 4, 1, 1'b0, 1'b1, 1'b0);
        push(t + 8, 2, 1'b0, 1'b1, 1'b0);
        wait_cyc(t + 9);
        @(posedge clk);
        #1;
        push(t + 10, 0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        wait_cyc(t + 12); reset_n = 1'b1;
        wait_cyc(t + 20);

        fin_req = 1'b1;
    end

endmodule
